// File: rtl/sr_muldiv_unit_pkg.sv
// Shared encodings and FSM state type for the sr_cpu multi-cycle multiply/divide unit.
// Imported by the unit, its interface and the bench.
package sr_muldiv_unit_pkg;

   localparam logic [6:0] RVF7_MULDIV = 7'b0000001;
   localparam logic [2:0] RVF3_MUL    = 3'b000;
   localparam logic [2:0] RVF3_MULHU  = 3'b011;
   localparam logic [2:0] RVF3_DIVU   = 3'b101;
   localparam logic [2:0] RVF3_REMU   = 3'b111;

   localparam int MD_OP_DIV = 2;
   localparam int MD_OP_HI  = 1;

   typedef enum logic [1:0] {
      MD_STATE_IDLE = 2'd0,
      MD_STATE_RUN  = 2'd1,
      MD_STATE_DONE = 2'd2
   } md_state_e;

endpackage

// File: rtl/sr_muldiv_unit_if.sv
// Stall handshake between sr_cpu control and the multiply/divide unit.
// req is a level held for the whole instruction; busy freezes pc, and its single low cycle marks the result as valid.
interface sr_muldiv_unit_if #(parameter int XLEN = 32);
   import sr_muldiv_unit_pkg::*;

   logic            req;
   logic [2:0]      op;
   logic [XLEN-1:0] srcA;
   logic [XLEN-1:0] srcB;
   logic            busy;
   logic [XLEN-1:0] result;
   md_state_e       state;

   modport master (output req, op, srcA, srcB, input busy, result, state);
   modport slave  (input req, op, srcA, srcB, output busy, result, state);
endinterface

// File: rtl/sr_muldiv_step.sv
// One combinational iteration of the shared datapath: shift-add multiply (LSB first)
// or restoring divide, operating on the {hi, lo} accumulator pair.
module sr_muldiv_step #(
   parameter int XLEN = 32
) (
   input  logic            div,
   input  logic [XLEN-1:0] hi,
   input  logic [XLEN-1:0] lo,
   input  logic [XLEN-1:0] opnd,
   output logic [XLEN-1:0] hi_n,
   output logic [XLEN-1:0] lo_n
);

   logic [XLEN:0] sum;
   logic [XLEN:0] shifted;
   logic [XLEN:0] diff;
   logic          ge;

   always_comb begin
      sum     = {1'b0, hi} + {1'b0, (lo[0] ? opnd : {XLEN{1'b0}})};
      shifted = {hi, lo[XLEN-1]};
      diff    = shifted - {1'b0, opnd};
      ge      = (shifted >= {1'b0, opnd});
      hi_n    = '0;
      lo_n    = '0;
      if (div) begin
         // Remainder stays below the divisor, so a restored value always fits XLEN bits.
         hi_n = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
         lo_n = {lo[XLEN-2:0], ge};
      end else begin
         hi_n = sum[XLEN:1];
         lo_n = {sum[0], lo[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/sr_muldiv_unit.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU unit for sr_cpu: XLEN steps per operation,
// busy held combinationally until the single DONE cycle that delivers the result.
module sr_muldiv_unit
   import sr_muldiv_unit_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input logic                 clk,
   input logic                 rst_n,
   sr_muldiv_unit_if.slave     md
);

   md_state_e       state;
   md_state_e       state_n;
   logic [CNT_W-1:0] cnt;
   logic [XLEN-1:0] acc_hi;
   logic [XLEN-1:0] acc_lo;
   logic [XLEN-1:0] opnd;
   logic [XLEN-1:0] res_q;
   logic [XLEN-1:0] hi_n;
   logic [XLEN-1:0] lo_n;
   logic            op_div;
   logic            op_hi;
   logic            last;
   logic            op_unused;

   // funct3 bit 0 does not distinguish any of the supported operations.
   assign op_unused = md.op[0];
   assign last      = (cnt == CNT_W'(XLEN - 1));

   sr_muldiv_step #(.XLEN(XLEN)) u_step (
      .div  (op_div),
      .hi   (acc_hi),
      .lo   (acc_lo),
      .opnd (opnd),
      .hi_n (hi_n),
      .lo_n (lo_n)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= MD_STATE_IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         MD_STATE_IDLE: if (md.req) state_n = MD_STATE_RUN;
         MD_STATE_RUN: begin
            if (!md.req)  state_n = MD_STATE_IDLE;
            else if (last) state_n = MD_STATE_DONE;
         end
         MD_STATE_DONE: state_n = MD_STATE_IDLE;
         default:       state_n = MD_STATE_IDLE;
      endcase
   end

   // pcWe is combinational, so busy must rise in the same cycle as req.
   always_comb begin
      md.busy   = rst_n & md.req & (state != MD_STATE_DONE);
      md.state  = state;
      md.result = res_q;
   end

   // acc_lo holds the operand consumed bit by bit: multiplier for multiply, dividend for divide.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         opnd   <= '0;
         op_div <= 1'b0;
         op_hi  <= 1'b0;
         res_q  <= '0;
      end else begin
         case (state)
            MD_STATE_IDLE: begin
               if (md.req) begin
                  op_div <= md.op[MD_OP_DIV];
                  op_hi  <= md.op[MD_OP_HI];
                  acc_hi <= '0;
                  acc_lo <= md.op[MD_OP_DIV] ? md.srcA : md.srcB;
                  opnd   <= md.op[MD_OP_DIV] ? md.srcB : md.srcA;
                  cnt    <= '0;
               end
            end
            MD_STATE_RUN: begin
               if (md.req) begin
                  acc_hi <= hi_n;
                  acc_lo <= lo_n;
                  cnt    <= cnt + CNT_W'(1);
                  if (last) res_q <= op_hi ? hi_n : lo_n;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sr_muldiv_unit.sv
// Directed bench for sr_muldiv_unit: vector table for the arithmetic and latency,
// hand-written sequences for back-to-back, abort and mid-operation reset.
module tb_sr_muldiv_unit;
   import sr_muldiv_unit_pkg::*;

   localparam int XLEN    = 32;
   localparam int LATENCY = XLEN + 1;

   typedef struct {
      logic [2:0]      op;
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
      logic [XLEN-1:0] exp;
      bit              chg_a;
   } vec_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;
   vec_t vecs[12];

   sr_muldiv_unit_if #(.XLEN(XLEN)) md ();

   sr_muldiv_unit #(.XLEN(XLEN), .CNT_W(6)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .md    (md.slave)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
      end
   endtask

   // Called just after a posedge: presents an op, counts busy-high cycles until the
   // DONE cycle, samples the result there, and returns just after the following edge.
   task automatic run_op(input logic [2:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input bit chg_a, input bit keep_req,
                         output logic [XLEN-1:0] r, output int n, output md_state_e st);
      md.op   = o;
      md.srcA = a;
      md.srcB = b;
      md.req  = 1'b1;
      n = 0;
      while (1) begin
         @(negedge clk);
         if (!md.busy) break;
         n++;
         if (chg_a && n == 2) md.srcA = '0;
         if (n > 100) break;
      end
      r  = md.result;
      st = md.state;
      @(posedge clk);
      #1;
      if (!keep_req) md.req = 1'b0;
   endtask

   initial begin
      logic [XLEN-1:0] r;
      int              n;
      md_state_e       st;

      checks   = 0;
      failures = 0;
      vecs[0]  = '{RVF3_MUL,   32'd7,        32'd6,        32'd42,       1'b0};
      vecs[1]  = '{RVF3_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};
      vecs[2]  = '{RVF3_MUL,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0};
      vecs[3]  = '{RVF3_DIVU,  32'd100,      32'd7,        32'd14,       1'b0};
      vecs[4]  = '{RVF3_REMU,  32'd100,      32'd7,        32'd2,        1'b0};
      vecs[5]  = '{RVF3_DIVU,  32'd100,      32'd7,        32'd14,       1'b1};
      vecs[6]  = '{RVF3_REMU,  32'd100,      32'd7,        32'd2,        1'b1};
      vecs[7]  = '{RVF3_DIVU,  32'h00001234, 32'd0,        32'hFFFFFFFF, 1'b0};
      vecs[8]  = '{RVF3_REMU,  32'h00001234, 32'd0,        32'h00001234, 1'b0};
      vecs[9]  = '{RVF3_MULHU, 32'h80000000, 32'd4,        32'h00000002, 1'b0};
      vecs[10] = '{RVF3_MUL,   32'h12345678, 32'h10,       32'h23456780, 1'b0};
      vecs[11] = '{RVF3_DIVU,  32'hFFFFFFFF, 32'h10,       32'h0FFFFFFF, 1'b0};

      // reset with req already high: busy must stay low
      rst_n   = 1'b0;
      md.req  = 1'b1;
      md.op   = RVF3_MUL;
      md.srcA = 32'd1;
      md.srcB = 32'd1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", {31'd0, md.busy}, 32'd0);
      check("reset_result", md.result, 32'd0);
      check("reset_state", {30'd0, md.state}, {30'd0, MD_STATE_IDLE});
      md.req = 1'b0;
      rst_n  = 1'b1;
      @(posedge clk);
      #1;

      // vector table
      for (int i = 0; i < 12; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].chg_a, 1'b0, r, n, st);
         check($sformatf("vec%0d_result", i), r, vecs[i].exp);
         check($sformatf("vec%0d_busy_cycles", i), n, LATENCY);
         check($sformatf("vec%0d_done_state", i), {30'd0, st}, {30'd0, MD_STATE_DONE});
      end

      // back-to-back with req held high: one busy-low cycle between ops
      run_op(RVF3_MUL, 32'd3, 32'd5, 1'b0, 1'b1, r, n, st);
      check("b2b_mul_result", r, 32'd15);
      check("b2b_mul_busy_cycles", n, LATENCY);
      check("b2b_idle_busy", {31'd0, md.busy}, 32'd1);
      run_op(RVF3_DIVU, 32'd9, 32'd2, 1'b0, 1'b0, r, n, st);
      check("b2b_div_result", r, 32'd4);
      check("b2b_div_busy_cycles", n, LATENCY);

      // abort at RUN step 10: result keeps 4
      md.op   = RVF3_DIVU;
      md.srcA = 32'd1000;
      md.srcB = 32'd3;
      md.req  = 1'b1;
      @(posedge clk);
      repeat (10) @(posedge clk);
      #1;
      check("abort_state_run", {30'd0, md.state}, {30'd0, MD_STATE_RUN});
      md.req = 1'b0;
      #1;
      check("abort_busy", {31'd0, md.busy}, 32'd0);
      @(posedge clk);
      #1;
      check("abort_state_idle", {30'd0, md.state}, {30'd0, MD_STATE_IDLE});
      repeat (40) @(posedge clk);
      #1;
      check("abort_result_kept", md.result, 32'd4);
      run_op(RVF3_MUL, 32'd11, 32'd13, 1'b0, 1'b0, r, n, st);
      check("after_abort_result", r, 32'd143);
      check("after_abort_busy_cycles", n, LATENCY);

      // reset pulse at RUN step 10: result cleared at once
      md.op   = RVF3_MUL;
      md.srcA = 32'h1000;
      md.srcB = 32'h1000;
      md.req  = 1'b1;
      @(posedge clk);
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_busy", {31'd0, md.busy}, 32'd0);
      check("midrst_result", md.result, 32'd0);
      check("midrst_state", {30'd0, md.state}, {30'd0, MD_STATE_IDLE});
      md.req = 1'b0;
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      run_op(RVF3_MULHU, 32'h00010000, 32'h00030000, 1'b0, 1'b0, r, n, st);
      check("after_rst_result", r, 32'd3);
      check("after_rst_busy_cycles", n, LATENCY);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sr_muldiv_unit.md
Name: sr_muldiv_unit

Overview:
Iterative multi-cycle multiply/divide responder for the sr_cpu stall handshake.
- The control unit raises a request level and holds it while the instruction sits in decode.
- This block drives busy combinationally so the CPU freezes pc; it drops busy for exactly one cycle when the result is valid, so the register file captures it and pc advances.
- It supports RV32M MUL, MULHU, DIVU and REMU using one shared 32-step shift datapath.

Parameters:
XLEN, 32, operand/result width; the iteration count equals XLEN.
CNT_W, 6, step counter width; must satisfy 2^CNT_W > XLEN.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req  in  1  multiCycleExt from control; level, held for the whole instruction
op  in  3  funct3 of the instruction: bit2 = divide, bit1 = high half / remainder
srcA  in  XLEN  rs1 value (multiplicand / dividend)
srcB  in  XLEN  rs2 value (multiplier / divisor)
busy  out  1  stall request to control (combinational)
result  out  XLEN  registered result, selected to the register-file write port by wdSrc

Behaviour:
- Reset: asynchronous on rst_n low.
  - state=IDLE, counter=0, accumulators=0, result=0.
  - busy=0 while rst_n is low, regardless of req.
- busy definition: busy = req & (state != DONE). busy is high in the same cycle req first rises; this is required because pcWe is combinational.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If req=1 at the clock edge: latch srcA, srcB and op[2:1]; clear the accumulators; counter=0; go to RUN.
  - Operand changes after the latch edge are ignored.
- RUN: one step per clock, counter increments.
  - Multiply: shift-add. Product register is 2*XLEN, multiplier LSB first.
  - Divide: restoring. Remainder shifts left by one, takes the next dividend MSB; if remainder >= divisor, subtract and set quotient bit = 1.
  - When counter == XLEN-1 at the edge: load result and go to DONE.
    - Multiply: low word if op[1]=0, high word if op[1]=1.
    - Divide: quotient if op[1]=0, remainder if op[1]=1.
- DONE: busy=0 for exactly this cycle; result is stable. Next edge always goes to IDLE.
- Back-to-back: if req is still high in the following cycle (next M instruction), IDLE starts a fresh operation from the new operands. There is always exactly one busy-low cycle between consecutive operations.
- Latency: busy high for XLEN+1 cycles (IDLE + XLEN RUN steps); total instruction time XLEN+2 cycles.
- result holds its last value until the next DONE load. It is not cleared at the start of an operation.
- Divide by zero: quotient = all ones, remainder = dividend (RISC-V rule). Fixed latency, no early out.
- Unsigned only. MULH/MULHSU/DIV/REM encodings execute as their unsigned counterparts selected by op[2:1]; control must not issue them.
- Abort: req=0 while in RUN forces IDLE on the next edge. result is unchanged and busy is 0.
- Reset mid-operation: immediate IDLE, result=0.
- Arithmetic: all sums/differences one bit wider than operands; no overflow flags.

Decomposition:
- Shared header sr_cpu.vh:
  - RVF7_MULDIV and RVF3_MUL/MULHU/DIVU/REMU encodings.
  - MD_STATE_IDLE/RUN/DONE localparams.
  - MD_OP_DIV bit index (2) and MD_OP_HI bit index (1).
- Natural sub-module: sr_muldiv_step. Purely combinational single iteration: takes accumulator pair + divisor/multiplicand + mode, returns the next accumulator pair. Instantiated once; the FSM and counter stay in sr_muldiv_unit.

Test Plan:
1. req=1, op=000, srcA=7, srcB=6 → busy high exactly 33 cycles from req rise; in DONE, busy=0 and result=42.
2. op=011, srcA=srcB=0xFFFFFFFF → result 0xFFFFFFFE. Repeat with op=000 → result 0x00000001.
3. op=101, srcA=100, srcB=7 → result 14. Repeat with op=111 → result 2. Also change srcA to 0 one cycle after req rises → results unaffected.
4. op=101, srcA=0x1234, srcB=0 → result 0xFFFFFFFF. Repeat with op=111 → result 0x00001234.
5. req held high across two ops (MUL 3*5, then DIVU 9/2 with new operands presented after DONE) → results 15 then 4; busy low exactly one cycle between them.
6. rst_n pulsed low at RUN step 10 → busy=0 and result=0 immediately; next req completes normally. Separately, req dropped at RUN step 10 → IDLE, busy=0, result keeps its previous value.
